ddr3_frame_port_arbiter: RTL and testbench

- Shares the single DDR3 EMIF Avalon-MM port between two requesters:
  - the camera frame writer (write-only, burst master);
  - the PCIe DMA frame reader (read-only, burst master).
- Arbitrates at burst granularity with weighted round-robin.
- Bounds outstanding read words so that EMIF read latency never overruns the reader's FIFO.
- Sits between the video/DMA masters and mem_if_ddr3_emif_0 inside the top-level system.

---
 rtl/ddr3_frame_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr3_frame_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_frame_port_arbiter.sv
// Burst-granular weighted round-robin arbiter sharing one DDR3 EMIF Avalon-MM port between a write and a read master.
// One registered idle cycle between bursts; waitrequests mirror the EMIF during a granted burst; read commands are throttled on in-flight words.
module ddr3_frame_port_arbiter #(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 128,
  parameter int BURST_W      = 4,
  parameter int WR_WEIGHT    = 4,
  parameter int MAX_RD_WORDS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic [BURST_W-1:0]  wr_burstcount,
  input  logic                wr_write,
  input  logic [DATA_W-1:0]   wr_writedata,
  input  logic [DATA_W/8-1:0] wr_byteenable,
  output logic                wr_waitrequest,
  input  logic [ADDR_W-1:0]   rd_address,
  input  logic [BURST_W-1:0]  rd_burstcount,
  input  logic                rd_read,
  output logic                rd_waitrequest,
  output logic [DATA_W-1:0]   rd_readdata,
  output logic                rd_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [BURST_W-1:0]  m_burstcount,
  output logic                m_write,
  output logic                m_read,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [5:0]          rd_words_outstanding
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_t;

  localparam int STREAK_W = (WR_WEIGHT < 1) ? 1 : $clog2(WR_WEIGHT + 1);

  state_t               state_q;
  logic                 last_grant_q;  // 1 = read was granted last
  logic [STREAK_W-1:0]  streak_q;
  logic [STREAK_W-1:0]  streak_inc;
  logic [BURST_W-1:0]   beat_q;
  logic [BURST_W-1:0]   wr_len_q;
  logic [BURST_W-1:0]   burst_len;
  logic [5:0]           out_q;
  logic [5:0]           out_d;
  logic [6:0]           rd_sum;
  logic [6:0]           out_inc;
  logic                 rd_ok;
  logic                 grant_wr;
  logic                 grant_rd;
  logic                 wr_acc;
  logic                 wr_last;
  logic                 rd_acc;

  assign rd_sum   = {1'b0, out_q} + 7'(rd_burstcount);
  assign rd_ok    = rd_read && (rd_sum <= 7'(MAX_RD_WORDS));
  assign grant_wr = wr_write && (!rd_ok || (streak_q < STREAK_W'(WR_WEIGHT)));
  assign grant_rd = rd_ok && !grant_wr;

  assign streak_inc = (streak_q >= STREAK_W'(WR_WEIGHT)) ? streak_q : streak_q + 1'b1;

  // The first beat carries the burst length; later beats use the captured copy.
  assign burst_len = (beat_q == '0) ? wr_burstcount : wr_len_q;
  assign wr_acc    = (state_q == WR_BURST) && wr_write && !m_waitrequest;
  assign wr_last   = wr_acc && (beat_q == burst_len - 1'b1);
  assign rd_acc    = (state_q == RD_CMD) && rd_read && !m_waitrequest;

  assign out_inc = {1'b0, out_q} + (rd_acc ? 7'(rd_burstcount) : 7'd0);

  always_comb begin
    out_d = 6'(out_inc);
    if (m_readdatavalid && (out_inc != 7'd0)) begin
      out_d = 6'(out_inc - 7'd1);
    end
  end

  always_comb begin
    m_write        = 1'b0;
    m_read         = 1'b0;
    wr_waitrequest = 1'b1;
    rd_waitrequest = 1'b1;
    m_address      = wr_address;
    m_burstcount   = wr_burstcount;
    case (state_q)
      WR_BURST: begin
        m_write        = wr_write;
        wr_waitrequest = m_waitrequest;
      end
      RD_CMD: begin
        m_read         = rd_read;
        m_address      = rd_address;
        m_burstcount   = rd_burstcount;
        rd_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
  end

  assign m_writedata          = wr_writedata;
  assign m_byteenable         = wr_byteenable;
  assign rd_readdata          = m_readdata;
  assign rd_readdatavalid     = m_readdatavalid;
  assign rd_words_outstanding = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      streak_q     <= '0;
      beat_q       <= '0;
      wr_len_q     <= '0;
      out_q        <= '0;
    end else begin
      out_q <= out_d;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q      <= WR_BURST;
            beat_q       <= '0;
            last_grant_q <= 1'b0;
            // Only a write that won against a waiting read counts toward the weight.
            if (rd_read) begin
              streak_q <= last_grant_q ? STREAK_W'(1) : streak_inc;
            end
          end else if (grant_rd) begin
            state_q      <= RD_CMD;
            last_grant_q <= 1'b1;
            streak_q     <= '0;
          end
        end
        WR_BURST: begin
          if (wr_acc) begin
            if (beat_q == '0) begin
              wr_len_q <= wr_burstcount;
            end
            if (wr_last) begin
              state_q <= IDLE;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        RD_CMD: begin
          if (rd_acc || !rd_read) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_frame_port_arbiter.sv
// Bench for ddr3_frame_port_arbiter: bus-functional masters and EMIF around the DUT, with a transaction-level model of grants and in-flight read words.
module tb_ddr3_frame_port_arbiter;
  localparam int ADDR_W = 27, DATA_W = 128, BURST_W = 4, WR_WEIGHT = 4, MAX_RD_WORDS = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [ADDR_W-1:0]   wr_address, rd_address, m_address;
  logic [BURST_W-1:0]  wr_burstcount, rd_burstcount, m_burstcount;
  logic                wr_write, wr_waitrequest, rd_read, rd_waitrequest, rd_readdatavalid;
  logic [DATA_W-1:0]   wr_writedata, rd_readdata, m_writedata, m_readdata;
  logic [DATA_W/8-1:0] wr_byteenable, m_byteenable;
  logic                m_write, m_read, m_waitrequest, m_readdatavalid;
  logic [5:0]          rd_words_outstanding;

  always #5 clk = ~clk;

  ddr3_frame_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
                            .WR_WEIGHT(WR_WEIGHT), .MAX_RD_WORDS(MAX_RD_WORDS)) dut (
    .clk(clk), .reset(reset),
    .wr_address(wr_address), .wr_burstcount(wr_burstcount), .wr_write(wr_write),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable), .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address), .rd_burstcount(rd_burstcount), .rd_read(rd_read),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .rd_words_outstanding(rd_words_outstanding)
  );

  always @(posedge clk) begin
    if (!reset) begin
      a_wr_bc: assert (!(wr_write && wr_burstcount == '0)) else $error("zero write burstcount");
      a_rd_bc: assert (!(rd_read && rd_burstcount == '0)) else $error("zero read burstcount");
    end
  end

  int checks = 0, errors = 0;
  int wr_bursts, wr_len, wr_beat, wr_gap_pct, wr_rand_len;
  int rd_bursts, rd_len, rd_rand_len;
  int wait_mode, ret_pending, ret_allow, ret_gap_pct;
  int model_out, emif_wbeat, emif_wlen;
  logic [DATA_W-1:0] cur_wdat;
  logic [DATA_W-1:0] sent_q[$], got_q[$];
  byte grant_log[$], exp_log[$];

  logic s_reset, s_wacc, s_racc, s_mwrite, s_mread, s_mwait, s_wwait, s_rwait, s_rvld;
  logic [DATA_W-1:0]  s_mwdat, s_rdat, s_mrdat;
  logic [BURST_W-1:0] s_mburst, s_rburst;

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive();
    wr_write      = (wr_bursts > 0) && ($urandom_range(99) >= 32'(wr_gap_pct));
    wr_writedata  = cur_wdat;
    wr_burstcount = BURST_W'(wr_len);
    wr_address    = ADDR_W'($urandom());
    wr_byteenable = DATA_W'($urandom()) >> (DATA_W - DATA_W/8);
    rd_read       = rd_bursts > 0;
    rd_burstcount = BURST_W'(rd_len);
    rd_address    = ADDR_W'($urandom());
    case (wait_mode)
      0: m_waitrequest = 1'b0;
      1: m_waitrequest = ~m_waitrequest;
      2: m_waitrequest = 1'($urandom_range(1));
      default: ;
    endcase
    m_readdatavalid = (ret_pending > 0) && (ret_allow > 0) && ($urandom_range(99) >= 32'(ret_gap_pct));
    m_readdata      = rand_word();
  endtask

  // Sample at negedge, update the masters / EMIF / model at posedge, drive new inputs 1 time unit later.
  task automatic cycle();
    int n;
    @(negedge clk);
    s_reset = reset;  s_mwait = m_waitrequest;
    s_wacc = wr_write && !wr_waitrequest;  s_racc = rd_read && !rd_waitrequest;
    s_mwrite = m_write;  s_mread = m_read;  s_mwdat = m_writedata;  s_mburst = m_burstcount;
    s_wwait = wr_waitrequest;  s_rwait = rd_waitrequest;  s_rvld = m_readdatavalid;
    s_rburst = rd_burstcount;  s_rdat = rd_readdata;  s_mrdat = m_readdata;
    @(posedge clk);
    if (s_reset) begin
      model_out = 0; emif_wbeat = 0;
    end else begin
      n = model_out + (s_racc ? int'(s_rburst) : 0);
      if (s_rvld && n > 0) n--;
      model_out = n;
      if (s_wacc) begin
        sent_q.push_back(cur_wdat);
        cur_wdat = rand_word();
        wr_beat++;
        if (wr_beat == wr_len) begin
          wr_beat = 0; wr_bursts--;
          if (wr_rand_len != 0) wr_len = $urandom_range(1, 8);
        end
      end
      if (s_racc) begin
        rd_bursts--; ret_pending += int'(s_rburst);
        if (rd_rand_len != 0) rd_len = $urandom_range(1, 8);
      end
      if (s_mwrite && !s_mwait) begin
        got_q.push_back(s_mwdat);
        if (emif_wbeat == 0) begin grant_log.push_back("W"); emif_wlen = int'(s_mburst); end
        emif_wbeat++;
        if (emif_wbeat == emif_wlen) emif_wbeat = 0;
      end
      if (s_mread && !s_mwait) grant_log.push_back("R");
    end
    if (s_rvld) begin
      if (ret_pending > 0) ret_pending--;
      if (ret_allow > 0) ret_allow--;
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    wr_bursts = 0; rd_bursts = 0; wr_beat = 0; wr_gap_pct = 0; wr_rand_len = 0; rd_rand_len = 0;
    wait_mode = 0; ret_pending = 0; ret_allow = 0; ret_gap_pct = 0; wr_len = 1; rd_len = 1;
    reset = 1'b1; drive(); cycle(); cycle(); reset = 1'b0; drive();
    sent_q.delete(); got_q.delete(); grant_log.delete(); emif_wbeat = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_bursts = 1; wr_len = 4; rd_bursts = 1; rd_len = 2; drive();
    cycle(); cycle();
    checks++; if (wr_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr_wait: got %b want 1", wr_waitrequest); end
    checks++; if (rd_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_rd_wait: got %b want 1", rd_waitrequest); end
    checks++; if (m_write !== 1'b0 || m_read !== 1'b0) begin errors++; $display("FAIL reset_m_cmd: got write=%b read=%b want 0 0", m_write, m_read); end
    checks++; if (rd_words_outstanding !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rd_words_outstanding); end
    do_reset();
  endtask

  task automatic test_single_write();
    int cnt, first, wwait5;
    do_reset();
    wr_len = 4; wr_bursts = 1; drive();
    cnt = 0; first = -1; wwait5 = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_mwrite) begin
        cnt++;
        if (first < 0) begin
          first = i;
          checks++; if (s_mburst !== 4'd4) begin errors++; $display("FAIL sw_burstcount: got %0d want 4", s_mburst); end
        end
      end
      if (i == 5) wwait5 = int'(s_wwait);
      if (i >= 1 && i <= 4) begin
        checks++; if (s_rwait !== 1'b1) begin errors++; $display("FAIL sw_rd_wait cycle %0d: got %b want 1", i, s_rwait); end
      end
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL sw_beats: got %0d want 4", cnt); end
    checks++; if (first != 1) begin errors++; $display("FAIL sw_first_cycle: got %0d want 1", first); end
    checks++; if (wwait5 != 1) begin errors++; $display("FAIL sw_back_idle: wr_waitrequest got %0d want 1", wwait5); end
    checks++;
    if (got_q.size() != 4 || sent_q.size() != 4) begin errors++; $display("FAIL sw_data_count: got %0d sent %0d want 4", got_q.size(), sent_q.size()); end
    else for (int i = 0; i < 4; i++) if (got_q[i] !== sent_q[i]) begin errors++; $display("FAIL sw_data beat %0d: got %h want %h", i, got_q[i], sent_q[i]); break; end
  endtask

  task automatic test_write_backpressure();
    int n;
    do_reset();
    wr_len = 8; wr_bursts = 1; wait_mode = 1; drive();
    n = 0;
    while (wr_bursts > 0 && n < 60) begin
      cycle(); n++;
      if (s_mwrite) begin
        checks++; if (s_wwait !== s_mwait) begin errors++; $display("FAIL bp_mirror: wr_waitrequest %b want %b", s_wwait, s_mwait); end
      end
    end
    checks++; if (wr_bursts != 0) begin errors++; $display("FAIL bp_timeout: %0d bursts left want 0", wr_bursts); end
    checks++;
    if (got_q.size() != 8 || sent_q.size() != 8) begin errors++; $display("FAIL bp_data_count: got %0d sent %0d want 8", got_q.size(), sent_q.size()); end
    else for (int i = 0; i < 8; i++) if (got_q[i] !== sent_q[i]) begin errors++; $display("FAIL bp_data beat %0d: got %h want %h", i, got_q[i], sent_q[i]); break; end
  endtask

  task automatic test_contention();
    int n, w, r, streak;
    do_reset();
    wr_len = 4; wr_bursts = 10; rd_len = 4; rd_bursts = 2; ret_allow = 1000000; drive();
    // Transaction-level weighted round-robin with both masters always requesting
    exp_log.delete(); w = 10; r = 2; streak = 0;
    while (w > 0 || r > 0) begin
      if (w > 0 && (r == 0 || streak < WR_WEIGHT)) begin exp_log.push_back("W"); w--; if (r > 0) streak++; end
      else begin exp_log.push_back("R"); r--; streak = 0; end
    end
    n = 0;
    while ((wr_bursts > 0 || rd_bursts > 0) && n < 300) begin cycle(); n++; end
    checks++; if (wr_bursts != 0 || rd_bursts != 0) begin errors++; $display("FAIL ct_timeout: wr %0d rd %0d bursts left want 0", wr_bursts, rd_bursts); end
    checks++;
    if (grant_log.size() != exp_log.size()) begin errors++; $display("FAIL ct_grant_count: got %0d want %0d", grant_log.size(), exp_log.size()); end
    else for (int i = 0; i < exp_log.size(); i++) if (grant_log[i] !== exp_log[i]) begin errors++; $display("FAIL ct_grant %0d: got %c want %c", i, grant_log[i], exp_log[i]); break; end
  endtask

  task automatic test_read_throttle();
    int n;
    do_reset();
    rd_len = 8; rd_bursts = 5; drive();
    n = 0;
    while (rd_bursts > 1 && n < 50) begin cycle(); n++; end
    checks++; if (rd_bursts != 1) begin errors++; $display("FAIL rt_fill_timeout: %0d bursts left want 1", rd_bursts); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (s_rwait !== 1'b1) begin errors++; $display("FAIL rt_blocked: rd_waitrequest %b want 1", s_rwait); end
    end
    checks++; if (rd_words_outstanding !== 6'd32) begin errors++; $display("FAIL rt_full: got %0d want 32", rd_words_outstanding); end
    ret_allow = 1; m_readdatavalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (s_rwait !== 1'b1) begin errors++; $display("FAIL rt_still_blocked: rd_waitrequest %b want 1", s_rwait); end
    end
    checks++; if (rd_words_outstanding !== 6'd31) begin errors++; $display("FAIL rt_one_ret: got %0d want 31", rd_words_outstanding); end
    ret_allow = 7; m_readdatavalid = 1'b1;
    n = 0;
    while (rd_bursts > 0 && n < 40) begin
      cycle(); n++;
      checks++; if (rd_words_outstanding !== 6'(model_out)) begin errors++; $display("FAIL rt_count: got %0d want %0d", rd_words_outstanding, model_out); end
    end
    checks++; if (rd_bursts != 0) begin errors++; $display("FAIL rt_grant_timeout: read never granted"); end
    checks++; if (rd_words_outstanding !== 6'd32) begin errors++; $display("FAIL rt_after_grant: got %0d want 32", rd_words_outstanding); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    rd_len = 5; rd_bursts = 1; drive();
    n = 0;
    while (rd_bursts > 0 && n < 20) begin cycle(); n++; end
    cycle();
    checks++; if (rd_words_outstanding !== 6'd5) begin errors++; $display("FAIL sim_setup: got %0d want 5", rd_words_outstanding); end
    wait_mode = 3; m_waitrequest = 1'b1; rd_len = 4; rd_bursts = 1; drive();
    n = 0;
    while (m_read !== 1'b1 && n < 10) begin cycle(); n++; end
    checks++; if (m_read !== 1'b1) begin errors++; $display("FAIL sim_no_rd_cmd: m_read %b want 1", m_read); end
    m_waitrequest = 1'b0; m_readdatavalid = 1'b1; ret_allow = 1;
    cycle();
    checks++; if (s_racc !== 1'b1) begin errors++; $display("FAIL sim_accept: got %b want 1", s_racc); end
    checks++; if (rd_words_outstanding !== 6'd8 || model_out != 8) begin errors++; $display("FAIL sim_net: got %0d want 8", rd_words_outstanding); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    wr_len = 8; wr_bursts = 1; drive();
    n = 0;
    while (sent_q.size() < 2 && n < 20) begin cycle(); n++; end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (m_write !== 1'b0) begin errors++; $display("FAIL rmb_m_write: got %b want 0", m_write); end
    checks++; if (wr_waitrequest !== 1'b1 || rd_waitrequest !== 1'b1) begin errors++; $display("FAIL rmb_idle: wr_wait %b rd_wait %b want 1 1", wr_waitrequest, rd_waitrequest); end
    checks++; if (rd_words_outstanding !== 6'd0) begin errors++; $display("FAIL rmb_count: got %0d want 0", rd_words_outstanding); end
    wr_bursts = 0; wr_beat = 0; ret_pending = 3; ret_allow = 3; drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (rd_words_outstanding !== 6'd0) begin errors++; $display("FAIL rmb_stray: got %0d want 0", rd_words_outstanding); end
    end
    sent_q.delete(); got_q.delete(); wr_len = 4; wr_bursts = 1; drive();
    n = 0;
    while (wr_bursts > 0 && n < 20) begin cycle(); n++; end
    cycle();
    checks++; if (s_wwait !== 1'b1 || s_mwrite !== 1'b0) begin errors++; $display("FAIL rmb_restart_idle: wr_wait %b m_write %b want 1 0", s_wwait, s_mwrite); end
    checks++;
    if (got_q.size() != 4 || sent_q.size() != 4) begin errors++; $display("FAIL rmb_restart_data: got %0d sent %0d want 4", got_q.size(), sent_q.size()); end
    else for (int i = 0; i < 4; i++) if (got_q[i] !== sent_q[i]) begin errors++; $display("FAIL rmb_restart beat %0d: got %h want %h", i, got_q[i], sent_q[i]); break; end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    wr_rand_len = 1; rd_rand_len = 1; wr_len = $urandom_range(1, 8); rd_len = $urandom_range(1, 8);
    wr_bursts = 25; rd_bursts = 25; wr_gap_pct = 20; wait_mode = 2; ret_allow = 1000000; ret_gap_pct = 30;
    drive();
    n = 0;
    while ((wr_bursts > 0 || rd_bursts > 0 || ret_pending > 0) && n < 4000) begin
      cycle(); n++;
      checks++; if (rd_words_outstanding !== 6'(model_out)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", rd_words_outstanding, model_out); end
      checks++; if (model_out > MAX_RD_WORDS) begin errors++; $display("FAIL rnd_over_max: got %0d want <= %0d", model_out, MAX_RD_WORDS); end
      checks++; if (s_rdat !== s_mrdat) begin errors++; $display("FAIL rnd_readdata: got %h want %h", s_rdat, s_mrdat); end
    end
    checks++; if (n >= 4000) begin errors++; $display("FAIL rnd_timeout: wr %0d rd %0d ret %0d left want 0", wr_bursts, rd_bursts, ret_pending); end
    checks++;
    if (got_q.size() != sent_q.size()) begin errors++; $display("FAIL rnd_data_count: got %0d want %0d", got_q.size(), sent_q.size()); end
    else for (int i = 0; i < sent_q.size(); i++) if (got_q[i] !== sent_q[i]) begin errors++; $display("FAIL rnd_data beat %0d: got %h want %h", i, got_q[i], sent_q[i]); break; end
  endtask

  initial begin
    reset = 1'b1; m_waitrequest = 1'b0; m_readdatavalid = 1'b0; model_out = 0;
    emif_wbeat = 0; emif_wlen = 1; cur_wdat = rand_word();
    wr_bursts = 0; rd_bursts = 0; wr_beat = 0; wr_gap_pct = 0; wr_rand_len = 0; rd_rand_len = 0;
    wait_mode = 0; ret_pending = 0; ret_allow = 0; ret_gap_pct = 0; wr_len = 1; rd_len = 1;
    drive();
    test_reset();
    test_single_write();
    test_write_backpressure();
    test_contention();
    test_read_throttle();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
